// File: rtl/cva6_bht_predictor.sv
// cva6_bht_predictor: branch history table of 2-bit saturating counters, one prediction per fetch slot.
// Lookup is combinational on vpc_i; training from resolved branches is registered and has no bypass.
module cva6_bht_predictor #(
   parameter int unsigned VLEN            = 64,
   parameter int unsigned NR_ENTRIES      = 128,
   parameter int unsigned INSTR_PER_FETCH = 2
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       flush_bp_i,
   input  logic                       debug_mode_i,
   input  logic [VLEN-1:0]            vpc_i,
   input  logic                       bht_update_valid_i,
   input  logic [VLEN-1:0]            bht_update_pc_i,
   input  logic                       bht_update_taken_i,
   output logic [INSTR_PER_FETCH-1:0] bht_prediction_valid_o,
   output logic [INSTR_PER_FETCH-1:0] bht_prediction_taken_o
);
   localparam int unsigned OFFSET         = 1;
   localparam int unsigned ROW_ADDR_BITS  = $clog2(INSTR_PER_FETCH);
   localparam int unsigned NR_ROWS        = NR_ENTRIES / INSTR_PER_FETCH;
   localparam int unsigned ROW_INDEX_BITS = $clog2(NR_ROWS);
   localparam int unsigned IDX_TOP        = ROW_INDEX_BITS + ROW_ADDR_BITS + OFFSET;

   logic [NR_ROWS-1:0][INSTR_PER_FETCH-1:0]      valid_q;
   logic [NR_ROWS-1:0][INSTR_PER_FETCH-1:0][1:0] cnt_q;
   logic [ROW_INDEX_BITS-1:0] rd_row;
   logic [ROW_INDEX_BITS-1:0] up_row;
   logic [ROW_ADDR_BITS-1:0]  up_col;
   logic [1:0]                up_cnt;
   logic [1:0]                nxt_cnt;
   logic                      up_hit;
   logic                      unused_pc;

   assign rd_row    = vpc_i[IDX_TOP-1 -: ROW_INDEX_BITS];
   assign up_row    = bht_update_pc_i[IDX_TOP-1 -: ROW_INDEX_BITS];
   assign up_col    = bht_update_pc_i[ROW_ADDR_BITS+OFFSET-1 -: ROW_ADDR_BITS];
   assign up_cnt    = cnt_q[up_row][up_col];
   assign up_hit    = valid_q[up_row][up_col];
   assign unused_pc = ^{vpc_i[VLEN-1:IDX_TOP], vpc_i[ROW_ADDR_BITS+OFFSET-1:0],
                        bht_update_pc_i[VLEN-1:IDX_TOP], bht_update_pc_i[OFFSET-1:0]};

   // A fresh entry starts weakly biased toward the first observed direction.
   always_comb begin
      nxt_cnt = !up_hit            ? (bht_update_taken_i ? 2'b10 : 2'b01) :
                bht_update_taken_i ? (up_cnt == 2'b11 ? 2'b11 : up_cnt + 2'd1) :
                                     (up_cnt == 2'b00 ? 2'b00 : up_cnt - 2'd1);
   end

   always_comb begin
      bht_prediction_valid_o = valid_q[rd_row];
      bht_prediction_taken_o = '0;
      for (int i = 0; i < INSTR_PER_FETCH; i++)
         bht_prediction_taken_o[i] = valid_q[rd_row][i] & cnt_q[rd_row][i][1];
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= '0;
         cnt_q   <= '0;
      end else if (flush_bp_i) begin
         valid_q <= '0;
      end else if (bht_update_valid_i && !debug_mode_i) begin
         valid_q[up_row][up_col] <= 1'b1;
         cnt_q[up_row][up_col]   <= nxt_cnt;
      end
   end
endmodule

// File: tb/tb_cva6_bht_predictor.sv
// tb_cva6_bht_predictor: directed and randomized checks of the BHT against a flat table model.
module tb_cva6_bht_predictor;
   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b1;
   logic        flush_bp_i = 1'b0;
   logic        debug_mode_i = 1'b0;
   logic [63:0] vpc_i = '0;
   logic        bht_update_valid_i = 1'b0;
   logic [63:0] bht_update_pc_i = '0;
   logic        bht_update_taken_i = 1'b0;
   logic [1:0]  bht_prediction_valid_o;
   logic [1:0]  bht_prediction_taken_o;

   int checks = 0;
   int errors = 0;
   bit m_v[128];
   int m_c[128];

   cva6_bht_predictor dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .flush_bp_i(flush_bp_i), .debug_mode_i(debug_mode_i),
      .vpc_i(vpc_i), .bht_update_valid_i(bht_update_valid_i), .bht_update_pc_i(bht_update_pc_i),
      .bht_update_taken_i(bht_update_taken_i), .bht_prediction_valid_o(bht_prediction_valid_o),
      .bht_prediction_taken_o(bht_prediction_taken_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic int entry(input logic [63:0] pc);
      return int'(pc[7:1]);
   endfunction

   task automatic model_clear();
      for (int k = 0; k < 128; k++) begin
         m_v[k] = 1'b0;
         m_c[k] = 0;
      end
   endtask

   task automatic model_update();
      int e;
      if (flush_bp_i) begin
         for (int k = 0; k < 128; k++) m_v[k] = 1'b0;
      end else if (bht_update_valid_i && !debug_mode_i) begin
         e = entry(bht_update_pc_i);
         if (!m_v[e]) m_c[e] = bht_update_taken_i ? 2 : 1;
         else if (bht_update_taken_i) m_c[e] = (m_c[e] + 1 > 3) ? 3 : m_c[e] + 1;
         else m_c[e] = (m_c[e] - 1 < 0) ? 0 : m_c[e] - 1;
         m_v[e] = 1'b1;
      end
   endtask

   task automatic check_const(input string tag, input logic [1:0] ev, input logic [1:0] et);
      checks += 2;
      assert (bht_prediction_valid_o === ev) else begin
         errors++;
         $error("FAIL %s valid observed %b expected %b", tag, bht_prediction_valid_o, ev);
      end
      assert (bht_prediction_taken_o === et) else begin
         errors++;
         $error("FAIL %s taken observed %b expected %b", tag, bht_prediction_taken_o, et);
      end
   endtask

   task automatic check_model(input string tag);
      logic [1:0] ev, et;
      int e;
      for (int s = 0; s < 2; s++) begin
         e = entry({vpc_i[63:2], 1'(s), 1'b0});
         ev[s] = m_v[e];
         et[s] = m_v[e] && m_c[e] >= 2;
      end
      check_const(tag, ev, et);
   endtask

   // Drives one cycle of inputs, checks the pre-update lookup, then advances the model past the edge.
   task automatic cycle(input logic uv, input logic [63:0] upc, input logic ut,
                        input logic fl, input logic dbg, input logic [63:0] pc);
      vpc_i = pc;
      bht_update_valid_i = uv;
      bht_update_pc_i = upc;
      bht_update_taken_i = ut;
      flush_bp_i = fl;
      debug_mode_i = dbg;
      @(negedge clk_i);
      check_model("pre_edge");
      @(posedge clk_i);
      model_update();
      #1;
      bht_update_valid_i = 1'b0;
      flush_bp_i = 1'b0;
      debug_mode_i = 1'b0;
   endtask

   initial begin
      logic [63:0] upc, pc;
      model_clear();
      vpc_i = 64'h8000_0000;
      #2 rst_ni = 1'b0;
      #1 check_const("reset", 2'b00, 2'b00);
      @(negedge clk_i);
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(posedge clk_i);
      #1;

      cycle(1, 64'h8000_0006, 1, 0, 0, 64'h8000_0004);
      check_const("first_taken", 2'b10, 2'b10);
      repeat (3) cycle(1, 64'h8000_0006, 1, 0, 0, 64'h8000_0004);
      cycle(1, 64'h8000_0006, 0, 0, 0, 64'h8000_0004);
      check_const("sat_hi_nt1", 2'b10, 2'b10);
      cycle(1, 64'h8000_0006, 0, 0, 0, 64'h8000_0004);
      check_const("sat_hi_nt2", 2'b10, 2'b00);
      repeat (3) cycle(1, 64'h8000_0006, 0, 0, 0, 64'h8000_0004);
      check_const("sat_lo", 2'b10, 2'b00);
      cycle(1, 64'h8000_0006, 1, 0, 0, 64'h8000_0004);
      check_const("sat_lo_t1", 2'b10, 2'b00);
      cycle(1, 64'h8000_0006, 1, 0, 0, 64'h8000_0004);
      check_const("sat_lo_t2", 2'b10, 2'b10);

      cycle(1, 64'h8000_0010, 0, 0, 0, 64'h8000_0010);
      check_const("first_not_taken", 2'b01, 2'b00);

      cycle(1, 64'h8000_0004, 1, 0, 0, 64'h9000_0104);
      check_const("alias", 2'b11, 2'b11);

      vpc_i = 64'h8000_0020;
      bht_update_valid_i = 1'b1;
      bht_update_pc_i = 64'h8000_0020;
      bht_update_taken_i = 1'b1;
      @(negedge clk_i);
      check_const("collision_pre", 2'b00, 2'b00);
      @(posedge clk_i);
      model_update();
      #1;
      bht_update_valid_i = 1'b0;
      check_const("collision_post", 2'b01, 2'b01);

      cycle(1, 64'h8000_0020, 0, 0, 1, 64'h8000_0020);
      check_const("debug_no_change", 2'b01, 2'b01);

      cycle(1, 64'h8000_0030, 1, 1, 0, 64'h8000_0030);
      check_const("flush_drops_update", 2'b00, 2'b00);
      vpc_i = 64'h8000_0004;
      #1 check_const("flush_clears", 2'b00, 2'b00);

      for (int n = 0; n < 600; n++) begin
         upc = {$urandom, $urandom};
         upc[7:1] = 7'($urandom_range(0, 15));
         pc = {$urandom, $urandom};
         pc[7:2] = ($urandom_range(0, 3) == 0) ? upc[7:2] : 6'($urandom_range(0, 7));
         cycle($urandom_range(0, 3) != 0, upc, 1'($urandom), $urandom_range(0, 40) == 0,
               $urandom_range(0, 15) == 0, pc);
      end

      cycle(1, 64'h8000_0044, 1, 0, 0, 64'h8000_0044);
      check_const("pre_async_rst", 2'b01, 2'b01);
      #2 rst_ni = 1'b0;
      #1 check_const("async_rst", 2'b00, 2'b00);
      model_clear();
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(posedge clk_i);
      #1;
      cycle(0, 64'h0, 0, 0, 0, 64'h8000_0044);
      check_const("after_rst", 2'b00, 2'b00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
